// File: rtl/t_ff_pkg.sv
// Shared types for the toggle-flip-flop register bank.
package t_ff_pkg;

  localparam logic [1:0] MODE_HOLD_ENC   = 2'd0;
  localparam logic [1:0] MODE_TOGGLE_ENC = 2'd1;
  localparam logic [1:0] MODE_UP_ENC     = 2'd2;
  localparam logic [1:0] MODE_DOWN_ENC   = 2'd3;

  typedef enum logic [1:0] {
    MODE_HOLD   = MODE_HOLD_ENC,
    MODE_TOGGLE = MODE_TOGGLE_ENC,
    MODE_UP     = MODE_UP_ENC,
    MODE_DOWN   = MODE_DOWN_ENC
  } t_ff_mode_e;

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit T flip-flop with a per-edge force override and a per-instance reset value.
module t_ff_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic rst_val,
  input  logic t,
  input  logic force_en,
  input  logic force_val,
  output logic q
);

  // Toggle on t, unless a load/set/clear forces the bit this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every cell samples pre-edge values.
    if (!reset_n)      q <= rst_val;
    else if (force_en) q <= force_val;
    else               q <= q ^ t;
  end

endmodule

// File: rtl/t_ff_bank_counter.sv
// WIDTH-bit register bank of T flip-flop cells acting as masked toggle
// register, up/down counter (wrapping or saturating) or loadable register.
module t_ff_bank_counter
  import t_ff_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] t_mask,
  input  logic             sync_set,
  input  logic             sync_clear,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat
);

  t_ff_mode_e       mode_sel;
  logic [WIDTH-1:0] tv;
  logic [WIDTH-1:0] up_tv;
  logic [WIDTH-1:0] dn_tv;
  logic             force_en;
  logic [WIDTH-1:0] force_val;
  logic             wrap_next;
  logic             sat_next;

  assign mode_sel = t_ff_mode_e'(mode);
  assign at_max   = &q;
  assign at_min   = ~|q;

  // Ripple toggle vectors: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic ones;
    logic zeros;
    up_tv = '0;
    dn_tv = '0;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_tv[i] = ones;
      dn_tv[i] = zeros;
      ones     = ones & q[i];
      zeros    = zeros & ~q[i];
    end
  end

  // Priority: clear, set, hold (!enable), load, then the selected mode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    tv        = '0;
    force_en  = 1'b0;
    force_val = '0;
    wrap_next = 1'b0;
    sat_next  = 1'b0;
    if (sync_clear) begin
      force_en  = 1'b1;
      force_val = '0;
    end else if (sync_set) begin
      force_en  = 1'b1;
      force_val = '1;
    end else if (!enable) begin
      tv = '0;
    end else if (load) begin
      force_en  = 1'b1;
      force_val = load_value;
    end else begin
      case (mode_sel)
        MODE_TOGGLE: tv = t_mask;
        MODE_UP: begin
          if (at_max && SATURATE) begin
            sat_next = 1'b1;
          end else begin
            tv        = up_tv;
            wrap_next = at_max;
          end
        end
        MODE_DOWN: begin
          if (at_min && SATURATE) begin
            sat_next = 1'b1;
          end else begin
            tv        = dn_tv;
            wrap_next = at_min;
          end
        end
        default: tv = '0;
      endcase
    end
  end

  // One cell per bit; the reset value is taken bit by bit from RESET_VALUE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .rst_val   (RESET_VALUE[i]),
      .t         (tv[i]),
      .force_en  (force_en),
      .force_val (force_val[i]),
      .q         (q[i])
    );
  end

  // Event flags: one-cycle pulses reporting what the previous edge did.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else begin
      wrap <= wrap_next;
      sat  <= sat_next;
    end
  end

endmodule

// File: tb/tb_t_ff_bank_counter.sv
// Self-checking bench: three configurations of the bank driven by shared
// stimulus, compared every cycle against an arithmetic reference model.
module tb_t_ff_bank_counter;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] t_mask;
  logic       sync_set;
  logic       sync_clear;

  logic [7:0] q8;
  logic       at_max8, at_min8, wrap8, sat8;
  logic [3:0] q4;
  logic       at_max4, at_min4, wrap4, sat4;
  logic [7:0] qs;
  logic       at_maxs, at_mins, wraps, sats;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: index 0 = W8/A5/wrap, 1 = W4/3/wrap, 2 = W8/00/saturate.
  int          m_width [3] = '{8, 4, 8};
  bit          m_sat   [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] m_rv    [3] = '{32'hA5, 32'h3, 32'h0};
  logic [31:0] m_q     [3];
  bit          m_w     [3];
  bit          m_s     [3];

  t_ff_bank_counter #(.WIDTH(8), .RESET_VALUE(8'hA5), .SATURATE(1'b0)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value), .t_mask(t_mask), .sync_set(sync_set),
    .sync_clear(sync_clear), .q(q8), .at_max(at_max8), .at_min(at_min8),
    .wrap(wrap8), .sat(sat8));

  t_ff_bank_counter #(.WIDTH(4), .RESET_VALUE(4'h3), .SATURATE(1'b0)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value[3:0]), .t_mask(t_mask[3:0]), .sync_set(sync_set),
    .sync_clear(sync_clear), .q(q4), .at_max(at_max4), .at_min(at_min4),
    .wrap(wrap4), .sat(sat4));

  t_ff_bank_counter #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1'b1)) u_duts (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value), .t_mask(t_mask), .sync_set(sync_set),
    .sync_clear(sync_clear), .q(qs), .at_max(at_maxs), .at_min(at_mins),
    .wrap(wraps), .sat(sats));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] width_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // Next state from the behavioural rules: plain modular arithmetic.
  function automatic void model_next(input int w, input bit satp, input logic [31:0] cur,
                                     output logic [31:0] nq, output bit nw, output bit ns);
    logic [31:0] msk;
    msk = width_mask(w);
    nq  = cur;
    nw  = 1'b0;
    ns  = 1'b0;
    if (sync_clear)      nq = 32'h0;
    else if (sync_set)   nq = msk;
    else if (!enable)    nq = cur;
    else if (load)       nq = 32'(load_value) & msk;
    else begin
      case (mode)
        2'd1: nq = (cur ^ 32'(t_mask)) & msk;
        2'd2: begin
          if (cur == msk) begin
            if (satp) ns = 1'b1;
            else begin nq = 32'h0; nw = 1'b1; end
          end else nq = cur + 32'h1;
        end
        2'd3: begin
          if (cur == 32'h0) begin
            if (satp) ns = 1'b1;
            else begin nq = msk; nw = 1'b1; end
          end else nq = cur - 32'h1;
        end
        default: nq = cur;
      endcase
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [31:0] nq;
    bit          nw, ns;
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        m_q[i] <= m_rv[i] & width_mask(m_width[i]);
        m_w[i] <= 1'b0;
        m_s[i] <= 1'b0;
      end else begin
        model_next(m_width[i], m_sat[i], m_q[i], nq, nw, ns);
        m_q[i] <= nq;
        m_w[i] <= nw;
        m_s[i] <= ns;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("q8",      32'(q8),      m_q[0]);
      check("wrap8",   32'(wrap8),   32'(m_w[0]));
      check("sat8",    32'(sat8),    32'(m_s[0]));
      check("at_max8", 32'(at_max8), 32'(m_q[0] == 32'hFF));
      check("at_min8", 32'(at_min8), 32'(m_q[0] == 32'h0));
      check("q4",      32'(q4),      m_q[1]);
      check("wrap4",   32'(wrap4),   32'(m_w[1]));
      check("sat4",    32'(sat4),    32'(m_s[1]));
      check("at_max4", 32'(at_max4), 32'(m_q[1] == 32'hF));
      check("at_min4", 32'(at_min4), 32'(m_q[1] == 32'h0));
      check("qs",      32'(qs),      m_q[2]);
      check("wraps",   32'(wraps),   32'(m_w[2]));
      check("sats",    32'(sats),    32'(m_s[2]));
      check("at_maxs", 32'(at_maxs), 32'(m_q[2] == 32'hFF));
      check("at_mins", 32'(at_mins), 32'(m_q[2] == 32'h0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b1;
    enable     = 1'b0;
    mode       = 2'd0;
    load       = 1'b0;
    load_value = 8'h00;
    t_mask     = 8'h00;
    sync_set   = 1'b0;
    sync_clear = 1'b0;

    // Reset applies without a clock edge.
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_q8", 32'(q8), 32'hA5);
    check("rst_async_q4", 32'(q4), 32'h3);
    cmp_en = 1'b1;
    repeat (3) tick();
    check("rst_hold_q8", 32'(q8), 32'hA5);

    // Release with enable low: bank holds.
    reset_n = 1'b1;
    repeat (2) begin
      tick();
      check("rel_q8", 32'(q8), 32'hA5);
      check("rel_wrap8", 32'(wrap8), 32'h0);
      check("rel_sat8", 32'(sat8), 32'h0);
    end
    enable = 1'b1;
    mode   = 2'd0;
    tick();
    check("hold_q8", 32'(q8), 32'hA5);

    // Masked toggle twice returns to the start value.
    load = 1'b1; load_value = 8'h0F;
    tick();
    check("load_q8", 32'(q8), 32'h0F);
    load = 1'b0; mode = 2'd1; t_mask = 8'h3C;
    tick();
    check("tog1_q8", 32'(q8), 32'h33);
    check("tog1_wrap8", 32'(wrap8), 32'h0);
    tick();
    check("tog2_q8", 32'(q8), 32'h0F);
    check("tog2_wrap8", 32'(wrap8), 32'h0);

    // 4-bit up count wraps F -> 0.
    load = 1'b1; load_value = 8'h0E;
    tick();
    check("w4_load", 32'(q4), 32'hE);
    load = 1'b0; mode = 2'd2;
    tick();
    check("w4_q_f", 32'(q4), 32'hF);
    check("w4_at_max", 32'(at_max4), 32'h1);
    check("w4_wrap0", 32'(wrap4), 32'h0);
    tick();
    check("w4_q_0", 32'(q4), 32'h0);
    check("w4_wrap1", 32'(wrap4), 32'h1);
    check("w4_at_min", 32'(at_min4), 32'h1);
    mode = 2'd0;
    tick();
    check("w4_wrap_drop", 32'(wrap4), 32'h0);

    // Saturating down count holds at 0.
    load = 1'b1; load_value = 8'h00;
    tick();
    check("s_load", 32'(qs), 32'h0);
    load = 1'b0; mode = 2'd3;
    repeat (3) begin
      tick();
      check("s_down_q", 32'(qs), 32'h0);
      check("s_down_sat", 32'(sats), 32'h1);
    end
    mode = 2'd2;
    tick();
    check("s_up_q", 32'(qs), 32'h1);
    check("s_up_sat", 32'(sats), 32'h0);

    // Priority: clear > set > hold > load.
    sync_clear = 1'b1; sync_set = 1'b1; load = 1'b1; load_value = 8'h55;
    tick();
    check("pri_clear", 32'(q8), 32'h00);
    sync_clear = 1'b0;
    tick();
    check("pri_set", 32'(q8), 32'hFF);
    sync_set = 1'b0; enable = 1'b0;
    tick();
    check("pri_hold", 32'(q8), 32'hFF);

    // Reset pulse between edges while counting.
    enable = 1'b1; load = 1'b1; load_value = 8'h05;
    tick();
    load = 1'b0; mode = 2'd2;
    repeat (2) tick();
    check("mid_q8_07", 32'(q8), 32'h07);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_q8", 32'(q8), 32'hA5);
    check("mid_rst_wrap8", 32'(wrap8), 32'h0);
    #1 reset_n = 1'b1;
    tick();
    check("mid_resume_q8", 32'(q8), 32'hA6);

    // Randomized traffic, checked by the model each cycle.
    repeat (400) begin
      enable     = ($urandom_range(0, 9) != 0);
      mode       = 2'($urandom_range(0, 3));
      load       = ($urandom_range(0, 7) == 0);
      sync_set   = ($urandom_range(0, 19) == 0);
      sync_clear = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       load_value = 8'hFF;
        1:       load_value = 8'h00;
        default: load_value = 8'($urandom);
      endcase
      t_mask = 8'($urandom);
      tick();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
